k6502_core: RTL and testbench
=============================

# k6502_core

Reduced-instruction-set 6502-compatible CPU core, the processor block of the knes design. It drives a 16-bit address bus and an 8-bit bidirectional data bus to external memory (program ROM in the upper 32 KiB, RAM below). It executes a defined 6502 opcode subset with 6502 cycle counts and exposes internal state on debug ports.

## Interface
- X_BITS, default 3: width of the timing-state debug port `x`.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset: **one clock; reset is synchronous and active-high**.
- a  out  16  address bus, registered.
- d  inout  8  data bus.
  - Driven by the core only when rw=0.
  - High-Z otherwise.
- rw  out  1  1=read, 0=write, registered.
- sync  out  1  high during opcode-fetch cycles.
- x  out  X_BITS  current timing state T0..T5 (binary).
- pc  out  16  program counter.
- dl  out  16  operand latch: {high byte, low byte}.
- ir  out  8  instruction register.

## Operation
- Registers:
  - A, X, Y: 8 bits each.
  - P flags N, Z, C, V: packed as 7,1,0,6; other bits read 0.
  - pc, ir, dl.
- Memory model:
  - Memory is combinational on reads; d is sampled at the rising edge that ends the cycle.
  - On a write cycle, d carries the store data for the whole cycle.
- Reset:
  - While rst=1: a=FFFC, rw=1, sync=0, pc=0000, ir=EA, dl=0000, x=0, A=X=Y=00, P=00.
  - First cycle after release reads FFFC into dl[7:0].
  - Second cycle reads FFFD into dl[15:8] and loads pc=dl.
  - Third cycle is an opcode fetch at the vector.
- Opcode fetch (T0):
  - a=pc, sync=1; ir<=d, pc<=pc+1.
  - Every instruction ends by entering the next fetch.
- Supported opcodes, with cycle counts including fetch:
  - LDA/LDX/LDY #imm (A9/A2/A0, 2 cycles): update N, Z.
  - LDA/LDX/LDY abs (AD/AE/AC, 4 cycles): update N, Z.
  - STA/STX/STY abs (8D/8E/8C, 4 cycles): final cycle rw=0, d=register.
  - JMP abs (4C, 3 cycles): pc <= {hi, lo}.
  - ADC #imm (69, 2 cycles): 8-bit add with carry-in; update C, V, N, Z. Binary mode only.
  - AND/ORA/EOR #imm (29/09/49, 2 cycles): update N, Z.
  - INX, INY, DEX, DEY (E8, C8, CA, 88, 2 cycles): wrap mod 256; update N, Z.
  - TAX, TXA, TAY, TYA (AA, 8A, A8, 98, 2 cycles): update N, Z.
  - CLC, SEC (18, 38, 2 cycles).
  - BEQ, BNE, BCC, BCS (F0, D0, 90, B0): 2 cycles if not taken, 3 if taken.
    - Target = pc after operand + sign-extended offset, modulo 2^16.
    - No page-cross penalty.
  - NOP (EA, 2 cycles).
  - Any other opcode: executes as a 2-cycle NOP with no operand fetch.
- Operand fetches:
  - Immediate and branch operands read at pc; pc increments.
  - Absolute operands read lo then hi into dl; pc increments each time.
  - Data access at dl.
- Dummy cycles (second cycle of implied opcodes): a=pc, read, pc unchanged.
- pc wraps FFFF→0000.

## Timing
- a, rw, sync, x change only on rising clk edges.
- Register and flag results are visible at the start of the next opcode fetch.
- Asserting rst in any cycle, including mid-instruction or mid-write, aborts the instruction.
  - Next edge applies the reset values; rw=1 immediately.
  - No partial register update.
- Reset held for N cycles: the vector read begins on the first edge after rst falls.
- The core never drives d during reset.

## Test plan
- Reset vector:
  - Setup: FFFC=00, FFFD=80; rst high 2 cycles.
  - Required: a=FFFC, FFFD, then 8000 with sync=1; pc=8000.
- Load and store:
  - Program at 8000: A9 42 8D 00 02.
  - Required: rw=0 exactly on cycle 6 after fetch of 8000; a=0200, d=42.
  - Required: no other write cycles before that.
- Jump loop:
  - Program at 8000: 4C 00 80.
  - Required: sync pulses every 3 cycles; a sequence 8000, 8001, 8002 repeating.
- Arithmetic and flags:
  - Program: A9 7F 69 01.
  - Required: A=80, N=1, V=1, C=0, Z=0.
  - Follow-up: A9 FF 18 69 01 → A=00, Z=1, C=1.
- Branch:
  - Program: A2 02 CA D0 FD EA.
  - Required: DEX executes twice; the first BNE is taken in 3 cycles, the second is not taken in 2 cycles; X=00.
- Reset mid-write:
  - Stimulus: assert rst during the STA write cycle.
  - Required: next edge rw=1, a=FFFC; the vector sequence restarts.

Source files
------------

// File: rtl/k6502_core_if.sv
// k6502_core_if: registered address/control bus of the k6502 core.
// The tristate data bus stays a plain inout port on the core.
interface k6502_core_if;
  logic [15:0] a;
  logic        rw;
  logic        sync;

  modport master (output a, output rw, output sync);
  modport slave  (input a, input rw, input sync);
endinterface

// File: rtl/k6502_core.sv
// k6502_core: reduced 6502-compatible CPU with 6502 cycle counts.
// Bus outputs are registered: the comb block computes the address/control
// of the next cycle while capturing the data of the current one.
module k6502_core #(
  parameter int unsigned X_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  k6502_core_if.master      bus,
  inout  wire  [7:0]        d,
  output logic [X_BITS-1:0] x,
  output logic [15:0]       pc,
  output logic [15:0]       dl,
  output logic [7:0]        ir
);

  typedef enum logic [1:0] {StVecLo, StVecHi, StRun} phase_e;

  phase_e      r_phase, w_phase;
  logic [2:0]  r_t, w_t;
  logic [15:0] r_a, w_a, r_pc, w_pc, r_dl, w_dl;
  logic        r_rw, w_rw, r_sync, w_sync;
  logic [7:0]  r_dout, w_dout, r_ir, w_ir;
  logic [7:0]  r_acc, w_acc, r_xr, w_xr, r_yr, w_yr;
  logic        r_n, w_n, r_v, w_v, r_z, w_z, r_c, w_c;
  logic [15:0] w_pc_inc, w_abs;
  logic [8:0]  w_sum;
  logic [7:0]  w_res;
  logic        w_res_upd, w_fetch, w_taken, w_opnd;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_abs    = {d, r_dl[7:0]};
  assign w_sum    = {1'b0, r_acc} + {1'b0, d} + {8'd0, r_c};
  // Opcodes that read an operand byte in T1 (immediate, branch, absolute).
  assign w_opnd   = r_ir inside {8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49,
                                 8'hF0, 8'hD0, 8'h90, 8'hB0,
                                 8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C};

  // Branch condition for the instruction held in ir.
  always_comb begin
    case (r_ir)
      8'hF0:   w_taken = r_z;
      8'hD0:   w_taken = !r_z;
      8'h90:   w_taken = !r_c;
      8'hB0:   w_taken = r_c;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state: execute the current cycle and set up the next bus cycle.
  always_comb begin
    w_phase = r_phase;
    w_t     = r_t;
    w_a     = r_a;
    w_rw    = 1'b1;
    w_sync  = 1'b0;
    w_dout  = r_dout;
    w_pc    = r_pc;
    w_dl    = r_dl;
    w_ir    = r_ir;
    w_acc   = r_acc;
    w_xr    = r_xr;
    w_yr    = r_yr;
    w_n     = r_n;
    w_v     = r_v;
    w_z     = r_z;
    w_c     = r_c;
    w_res     = 8'h00;
    w_res_upd = 1'b0;
    w_fetch   = 1'b0;
    unique case (r_phase)
      StVecLo: begin
        w_dl[7:0] = d;
        w_a       = 16'hFFFD;
        w_phase   = StVecHi;
      end
      StVecHi: begin
        w_dl[15:8] = d;
        w_pc       = w_abs;
        w_phase    = StRun;
        w_fetch    = 1'b1;
      end
      default: begin
        case (r_t)
          3'd0: begin
            w_ir = d;
            w_pc = w_pc_inc;
            w_a  = w_pc_inc;
            w_t  = 3'd1;
          end
          3'd1: begin
            w_fetch = 1'b1;
            if (w_opnd) begin
              w_pc      = w_pc_inc;
              w_dl[7:0] = d;
            end
            case (r_ir)
              8'hA9: begin w_res = d; w_acc = w_res; w_res_upd = 1'b1; end
              8'hA2: begin w_res = d; w_xr = w_res; w_res_upd = 1'b1; end
              8'hA0: begin w_res = d; w_yr = w_res; w_res_upd = 1'b1; end
              8'h69: begin
                w_res     = w_sum[7:0];
                w_acc     = w_res;
                w_res_upd = 1'b1;
                w_c       = w_sum[8];
                w_v       = (r_acc[7] == d[7]) && (w_sum[7] != r_acc[7]);
              end
              8'h29: begin w_res = r_acc & d; w_acc = w_res; w_res_upd = 1'b1; end
              8'h09: begin w_res = r_acc | d; w_acc = w_res; w_res_upd = 1'b1; end
              8'h49: begin w_res = r_acc ^ d; w_acc = w_res; w_res_upd = 1'b1; end
              8'hE8: begin w_res = r_xr + 8'd1; w_xr = w_res; w_res_upd = 1'b1; end
              8'hC8: begin w_res = r_yr + 8'd1; w_yr = w_res; w_res_upd = 1'b1; end
              8'hCA: begin w_res = r_xr - 8'd1; w_xr = w_res; w_res_upd = 1'b1; end
              8'h88: begin w_res = r_yr - 8'd1; w_yr = w_res; w_res_upd = 1'b1; end
              8'hAA: begin w_res = r_acc; w_xr = w_res; w_res_upd = 1'b1; end
              8'h8A: begin w_res = r_xr; w_acc = w_res; w_res_upd = 1'b1; end
              8'hA8: begin w_res = r_acc; w_yr = w_res; w_res_upd = 1'b1; end
              8'h98: begin w_res = r_yr; w_acc = w_res; w_res_upd = 1'b1; end
              8'h18: w_c = 1'b0;
              8'h38: w_c = 1'b1;
              8'hF0, 8'hD0, 8'h90, 8'hB0: begin
                // Taken branch spends one dummy read at the post-operand pc.
                if (w_taken) begin
                  w_fetch = 1'b0;
                  w_a     = w_pc_inc;
                  w_t     = 3'd2;
                end
              end
              8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C: begin
                w_fetch = 1'b0;
                w_a     = w_pc_inc;
                w_t     = 3'd2;
              end
              default: ;
            endcase
          end
          3'd2: begin
            case (r_ir)
              8'h4C: begin
                w_dl[15:8] = d;
                w_pc       = w_abs;
                w_fetch    = 1'b1;
              end
              8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C: begin
                w_dl[15:8] = d;
                w_pc       = w_pc_inc;
                w_a        = w_abs;
                w_t        = 3'd3;
                if (!r_ir[5]) begin
                  w_rw   = 1'b0;
                  w_dout = (r_ir == 8'h8D) ? r_acc : (r_ir == 8'h8E) ? r_xr : r_yr;
                end
              end
              default: begin
                w_pc    = r_pc + {{8{r_dl[7]}}, r_dl[7:0]};
                w_fetch = 1'b1;
              end
            endcase
          end
          3'd3: begin
            w_fetch = 1'b1;
            case (r_ir)
              8'hAD:   begin w_res = d; w_acc = w_res; w_res_upd = 1'b1; end
              8'hAE:   begin w_res = d; w_xr = w_res; w_res_upd = 1'b1; end
              8'hAC:   begin w_res = d; w_yr = w_res; w_res_upd = 1'b1; end
              default: ;
            endcase
          end
          default: w_fetch = 1'b1;
        endcase
      end
    endcase
    if (w_res_upd) begin
      w_n = w_res[7];
      w_z = (w_res == 8'h00);
    end
    // Every instruction ends by fetching the next opcode at the new pc.
    if (w_fetch) begin
      w_a    = w_pc;
      w_sync = 1'b1;
      w_t    = 3'd0;
    end
  end

  // State register with synchronous reset; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= StVecLo;
      r_t     <= 3'd0;
      r_a     <= 16'hFFFC;
      r_rw    <= 1'b1;
      r_sync  <= 1'b0;
      r_dout  <= 8'h00;
      r_pc    <= 16'h0000;
      r_dl    <= 16'h0000;
      r_ir    <= 8'hEA;
      r_acc   <= 8'h00;
      r_xr    <= 8'h00;
      r_yr    <= 8'h00;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_phase <= w_phase;
      r_t     <= w_t;
      r_a     <= w_a;
      r_rw    <= w_rw;
      r_sync  <= w_sync;
      r_dout  <= w_dout;
      r_pc    <= w_pc;
      r_dl    <= w_dl;
      r_ir    <= w_ir;
      r_acc   <= w_acc;
      r_xr    <= w_xr;
      r_yr    <= w_yr;
      r_n     <= w_n;
      r_v     <= w_v;
      r_z     <= w_z;
      r_c     <= w_c;
    end
  end

  assign bus.a    = r_a;
  assign bus.rw   = r_rw;
  assign bus.sync = r_sync;
  // Release the data bus as soon as reset is seen, even mid-write.
  assign d        = (!r_rw && !rst) ? r_dout : 8'hzz;
  assign x        = X_BITS'(r_t);
  assign pc       = r_pc;
  assign dl       = r_dl;
  assign ir       = r_ir;

endmodule

// File: tb/tb_k6502_core.sv
// tb_k6502_core: directed sequences, an ALU vector table and a randomized
// program run checked cycle-by-cycle against an instruction-level model.
module tb_k6502_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  d;
  logic [2:0]  x;
  logic [15:0] pc, dl;
  logic [7:0]  ir;

  k6502_core_if bus();

  k6502_core #(.X_BITS(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .d(d), .x(x), .pc(pc), .dl(dl), .ir(ir)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign d = bus.rw ? mem[bus.a] : 8'hzz;

  int checks = 0;
  int failures = 0;

  logic [15:0] tr_a    [0:63];
  logic        tr_rw   [0:63];
  logic        tr_sync [0:63];
  logic [7:0]  tr_d    [0:63];
  logic [15:0] tr_pc   [0:63];

  typedef struct packed {
    logic [15:0] a;
    logic        rw;
    logic        sync;
    logic [7:0]  wd;
  } cyc_t;
  cyc_t exp_q[$];

  typedef struct {
    logic [7:0] cop, a_in, op, imm, ea;
    logic       en, ev, ez, ec;
  } vec_t;
  vec_t tbl [9];

  logic [7:0]  mm [0:65535];
  logic [15:0] m_pc;
  logic [7:0]  m_a, m_x, m_y;
  logic        m_n, m_v, m_z, m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock; DUT writes land in memory during the write cycle.
  task automatic tick();
    @(negedge clk);
    if (!bus.rw && !rst) mem[bus.a] = d;
  endtask

  task automatic setup_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
  endtask

  task automatic load(input logic [15:0] base, input logic [95:0] prog, input int len);
    for (int i = 0; i < len; i++) mem[base + 16'(i)] = prog[8*(len-1-i) +: 8];
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic run_trace(input int n);
    for (int i = 0; i < n; i++) begin
      tr_a[i] = bus.a; tr_rw[i] = bus.rw; tr_sync[i] = bus.sync;
      tr_d[i] = d; tr_pc[i] = pc;
      tick();
    end
  endtask

  task automatic push(input logic [15:0] a, input logic rw, input logic sync,
                      input logic [7:0] wd);
    exp_q.push_back('{a: a, rw: rw, sync: sync, wd: wd});
  endtask

  task automatic setnz(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  // Instruction-level reference: emits the expected bus cycles of one instruction.
  task automatic model_step();
    logic [7:0] op, lo, hi;
    logic [15:0] ea;
    int sum, ssum;
    logic tk;
    lo = 8'h00; hi = 8'h00; ea = 16'h0000;
    op = mm[m_pc]; push(m_pc, 1'b1, 1'b1, 8'h00); m_pc = m_pc + 16'd1;
    case (op)
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h29, 8'h09, 8'h49, 8'hF0, 8'hD0, 8'h90, 8'hB0: begin
        lo = mm[m_pc]; push(m_pc, 1'b1, 1'b0, 8'h00); m_pc = m_pc + 16'd1;
      end
      8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C: begin
        lo = mm[m_pc]; push(m_pc, 1'b1, 1'b0, 8'h00); m_pc = m_pc + 16'd1;
        hi = mm[m_pc]; push(m_pc, 1'b1, 1'b0, 8'h00); m_pc = m_pc + 16'd1;
        ea = {hi, lo};
      end
      default: push(m_pc, 1'b1, 1'b0, 8'h00);
    endcase
    case (op)
      8'hA9: begin m_a = lo; setnz(m_a); end
      8'hA2: begin m_x = lo; setnz(m_x); end
      8'hA0: begin m_y = lo; setnz(m_y); end
      8'h69: begin
        sum  = int'(m_a) + int'(lo) + int'(m_c);
        ssum = int'($signed(m_a)) + int'($signed(lo)) + int'(m_c);
        m_c  = (sum > 255);
        m_v  = (ssum > 127) || (ssum < -128);
        m_a  = 8'(sum);
        setnz(m_a);
      end
      8'h29: begin m_a = m_a & lo; setnz(m_a); end
      8'h09: begin m_a = m_a | lo; setnz(m_a); end
      8'h49: begin m_a = m_a ^ lo; setnz(m_a); end
      8'hE8: begin m_x = m_x + 8'd1; setnz(m_x); end
      8'hC8: begin m_y = m_y + 8'd1; setnz(m_y); end
      8'hCA: begin m_x = m_x - 8'd1; setnz(m_x); end
      8'h88: begin m_y = m_y - 8'd1; setnz(m_y); end
      8'hAA: begin m_x = m_a; setnz(m_x); end
      8'h8A: begin m_a = m_x; setnz(m_a); end
      8'hA8: begin m_y = m_a; setnz(m_y); end
      8'h98: begin m_a = m_y; setnz(m_a); end
      8'h18: m_c = 1'b0;
      8'h38: m_c = 1'b1;
      8'hF0, 8'hD0, 8'h90, 8'hB0: begin
        tk = (op == 8'hF0) ? m_z : (op == 8'hD0) ? !m_z : (op == 8'h90) ? !m_c : m_c;
        if (tk) begin
          push(m_pc, 1'b1, 1'b0, 8'h00);
          m_pc = 16'(int'(m_pc) + int'($signed(lo)));
        end
      end
      8'hAD, 8'hAE, 8'hAC: begin
        push(ea, 1'b1, 1'b0, 8'h00);
        if (op == 8'hAD) begin m_a = mm[ea]; setnz(m_a); end
        else if (op == 8'hAE) begin m_x = mm[ea]; setnz(m_x); end
        else begin m_y = mm[ea]; setnz(m_y); end
      end
      8'h8D: begin push(ea, 1'b0, 1'b0, m_a); mm[ea] = m_a; end
      8'h8E: begin push(ea, 1'b0, 1'b0, m_x); mm[ea] = m_x; end
      8'h8C: begin push(ea, 1'b0, 1'b0, m_y); mm[ea] = m_y; end
      8'h4C: m_pc = ea;
      default: ;
    endcase
  endtask

  initial begin
    logic [7:0] ops [0:28];
    int fidx [7];
    logic [15:0] fadr [7];
    int k;
    cyc_t e;

    tbl[0] = '{8'h18, 8'h7F, 8'h69, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h18, 8'hFF, 8'h69, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{8'h38, 8'h50, 8'h69, 8'h50, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h18, 8'h90, 8'h69, 8'hD0, 8'h60, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h38, 8'hF3, 8'h29, 8'h0F, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h18, 8'h01, 8'h09, 8'h80, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h18, 8'hFF, 8'h49, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h38, 8'h11, 8'hA9, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{8'h38, 8'h3C, 8'h69, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values, vector fetch and a JMP-to-self loop.
    setup_mem();
    load(16'h8000, 96'h4C0080, 3);
    rst = 1'b1;
    tick(); tick();
    chk("reset a", 32'(bus.a), 32'hFFFC);
    chk("reset rw/sync", {bus.rw, bus.sync}, 2'b10);
    chk("reset pc/dl", {pc, dl}, 32'h0);
    chk("reset ir/x", {ir, 5'(x)}, {8'hEA, 5'd0});
    chk("reset regs", {dut.r_acc, dut.r_xr, dut.r_yr, dut.r_n, dut.r_v, dut.r_z, dut.r_c}, 0);
    rst = 1'b0;
    run_trace(20);
    chk("vec a0", {tr_a[0], tr_sync[0]}, {16'hFFFC, 1'b0});
    chk("vec a1", {tr_a[1], tr_sync[1]}, {16'hFFFD, 1'b0});
    chk("vec pc", 32'(tr_pc[2]), 32'h8000);
    for (int i = 2; i < 20; i++)
      chk($sformatf("jmp loop c%0d", i), {tr_a[i], tr_sync[i]},
          {16'h8000 + 16'((i - 2) % 3), ((i - 2) % 3) == 0});

    // Load and store: exactly one write, on the sixth cycle of the program.
    setup_mem();
    load(16'h8000, 96'hA9428D00024C0580, 8);
    do_reset(2);
    run_trace(16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("sta rw c%0d", i), 32'(tr_rw[i]), (i == 7) ? 32'd0 : 32'd1);
    chk("sta addr/data", {tr_a[7], tr_d[7]}, {16'h0200, 8'h42});
    chk("sta mem", 32'(mem[16'h0200]), 32'h42);

    // ALU vector table.
    for (int t = 0; t < 9; t++) begin
      setup_mem();
      load(16'h8000, {tbl[t].a_in == tbl[t].a_in ? 32'h0 : 32'h0,
                      8'hA9, tbl[t].a_in, tbl[t].cop, tbl[t].op, tbl[t].imm,
                      8'h4C, 8'h05, 8'h80}, 8);
      do_reset(1);
      repeat (20) tick();
      chk($sformatf("alu%0d A", t), 32'(dut.r_acc), 32'(tbl[t].ea));
      chk($sformatf("alu%0d NVZC", t), {dut.r_n, dut.r_v, dut.r_z, dut.r_c},
          {tbl[t].en, tbl[t].ev, tbl[t].ez, tbl[t].ec});
    end

    // Branch: BNE taken once (3 cycles) then not taken (2 cycles).
    setup_mem();
    load(16'h8000, 96'hA202CAD0FDEA4C0680, 9);
    do_reset(1);
    run_trace(24);
    fidx = '{2, 4, 6, 9, 11, 13, 15};
    fadr = '{16'h8000, 16'h8002, 16'h8003, 16'h8002, 16'h8003, 16'h8005, 16'h8006};
    for (int i = 2; i < 16; i++) begin
      k = -1;
      for (int j = 0; j < 7; j++) if (fidx[j] == i) k = j;
      chk($sformatf("bne sync c%0d", i), 32'(tr_sync[i]), (k >= 0) ? 32'd1 : 32'd0);
      if (k >= 0) chk($sformatf("bne fetch c%0d", i), 32'(tr_a[i]), 32'(fadr[k]));
    end
    chk("bne X/Z", {dut.r_xr, dut.r_z}, {8'h00, 1'b1});

    // Reset asserted in the middle of the STA write cycle.
    setup_mem();
    load(16'h8000, 96'hA9428D00024C0580, 8);
    do_reset(1);
    repeat (7) tick();
    chk("midwr rw", 32'(bus.rw), 32'd0);
    rst = 1'b1;
    tick();
    chk("midwr abort", {bus.a, bus.rw, bus.sync}, {16'hFFFC, 1'b1, 1'b0});
    chk("midwr regs", 32'(dut.r_acc), 32'h0);
    rst = 1'b0;
    run_trace(4);
    chk("midwr vec", {tr_a[0], tr_a[1], tr_a[2], tr_sync[2]},
        {16'hFFFC, 16'hFFFD, 16'h8000, 1'b1});

    // Randomized program over the full address space versus the model.
    ops = '{8'hA9, 8'hA2, 8'hA0, 8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h4C,
            8'h69, 8'h29, 8'h09, 8'h49, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A,
            8'hA8, 8'h98, 8'h18, 8'h38, 8'hF0, 8'hD0, 8'h90, 8'hB0, 8'hEA};
    for (int i = 0; i < 65536; i++) begin
      mem[i] = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 28)] : 8'($urandom);
      mm[i]  = mem[i];
    end
    do_reset(2);
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
    m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
    exp_q.delete();
    push(16'hFFFC, 1'b1, 1'b0, 8'h00);
    push(16'hFFFD, 1'b1, 1'b0, 8'h00);
    m_pc = {mm[16'hFFFD], mm[16'hFFFC]};
    for (int cyc = 0; cyc < 4000 && failures < 40; cyc++) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("rnd regs c%0d", cyc),
            {dut.r_acc, dut.r_xr, dut.r_yr, dut.r_n, dut.r_v, dut.r_z, dut.r_c},
            {m_a, m_x, m_y, m_n, m_v, m_z, m_c});
        model_step();
      end
      e = exp_q.pop_front();
      chk($sformatf("rnd bus c%0d", cyc), {bus.a, bus.rw, bus.sync}, {e.a, e.rw, e.sync});
      if (!e.rw) chk($sformatf("rnd wdata c%0d", cyc), 32'(d), 32'(e.wd));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
